// File: rtl/counter_job_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// counter_job_arbiter_pkg
// Shared definitions for the counter job arbiter slice:
//   - state_e          : controller FSM encoding (IDLE/LOAD/RUN/DONE, 2 bits)
//   - NUM_REQ          : number of requesters (2)
//   - CJA_DEFAULT_WIDTH: default counter / start / length width
//   - pick_winner      : two-requester arbitration helper
//   - req_onehot       : requester index to one-hot vector
// Policy macro used by the slice: CNT_ARB_ROUND_ROBIN_EN (see top module).
// -----------------------------------------------------------------------------
package counter_job_arbiter_pkg;

    localparam int unsigned NUM_REQ           = 2;
    localparam int unsigned CJA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // A lone requester always wins; on contention prefer1 decides.
    function automatic logic pick_winner(input logic [NUM_REQ-1:0] valid,
                                         input logic               prefer1);
        logic win;
        case (valid)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = prefer1;
            default: win = 1'b0;
        endcase
        return win;
    endfunction

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        logic [NUM_REQ-1:0] vec;
        if (idx) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/counter_job_arbiter_if.sv
// -----------------------------------------------------------------------------
// counter_job_arbiter_if
// Bundles the job handshake and status signals of counter_job_arbiter.
//   req_valid  [2]     job request per requester        (master -> slave)
//   req_ready  [2]     job accept per requester         (slave  -> master)
//   req_start0/1 [W]   counter start value per requester (master -> slave)
//   req_len0/1   [W]   increment count per requester     (master -> slave)
//   pause              freezes counting while running    (master -> slave)
//   count      [W]     shared counter value              (slave  -> master)
//   busy               controller not idle               (slave  -> master)
//   owner              requester owning the current job  (slave  -> master)
//   done       [2]     one-cycle completion pulse        (slave  -> master)
// -----------------------------------------------------------------------------
interface counter_job_arbiter_if #(
    parameter int unsigned WIDTH = counter_job_arbiter_pkg::CJA_DEFAULT_WIDTH
);
    import counter_job_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [WIDTH-1:0]   req_start0;
    logic [WIDTH-1:0]   req_start1;
    logic [WIDTH-1:0]   req_len0;
    logic [WIDTH-1:0]   req_len1;
    logic               pause;
    logic [WIDTH-1:0]   count;
    logic               busy;
    logic               owner;
    logic [NUM_REQ-1:0] done;

    modport master (
        output req_valid, req_start0, req_start1, req_len0, req_len1, pause,
        input  req_ready, count, busy, owner, done
    );

    modport slave (
        input  req_valid, req_start0, req_start1, req_len0, req_len1, pause,
        output req_ready, count, busy, owner, done
    );

endinterface

// File: rtl/counter_job_arbiter_ctr_load.sv
// -----------------------------------------------------------------------------
// ctr_load
// Loadable up-counter shared by all jobs. Wraps modulo 2^WIDTH.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (value -> 0)
//   load     in   load load_val (has priority over inc)
//   load_val in   value to load
//   inc      in   increment by one
//   value    out  registered counter value
// -----------------------------------------------------------------------------
module ctr_load #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_r;

    // Counter register: reset, load, increment, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= {WIDTH{1'b0}};
        end else if (load) begin
            value_r <= load_val;
        end else if (inc) begin
            value_r <= value_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/counter_job_arbiter.sv
// -----------------------------------------------------------------------------
// counter_job_arbiter
// Accepts counting jobs from two requesters. A job (start, len) loads the
// shared counter with start and then increments it len times (pause stalls
// the increments), after which done[owner] pulses for one cycle.
// Ports:
//   clk   in   sole clock, rising edge
//   rst   in   synchronous active-high reset; aborts any job silently
//   bus   slave modport of counter_job_arbiter_if (handshake + status)
// Configuration:
//   CNT_ARB_ROUND_ROBIN_EN defined   -> round-robin on contention (rr_last)
//   CNT_ARB_ROUND_ROBIN_EN undefined -> fixed priority, requester 0 wins
// -----------------------------------------------------------------------------
module counter_job_arbiter
    import counter_job_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = CJA_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_job_arbiter_if.slave bus
);

    state_e             state_r;
    state_e             state_next_s;
    logic [WIDTH-1:0]   start_r;
    logic [WIDTH-1:0]   len_r;
    logic [WIDTH-1:0]   remaining_r;
    logic [WIDTH-1:0]   count_s;
    logic               owner_r;
    logic               busy_r;
    logic [NUM_REQ-1:0] done_r;
    logic [NUM_REQ-1:0] ready_s;
    logic               grant_s;
    logic               prefer1_s;
    logic               accept_s;
    logic               load_s;
    logic               inc_s;

`ifdef CNT_ARB_ROUND_ROBIN_EN
    logic               rr_last_r;

    // On contention the requester not granted last time wins.
    assign prefer1_s = ~rr_last_r;
`else
    assign prefer1_s = 1'b0;
`endif

    // Grant decode: ready only in IDLE, only to the winner, never during reset.
    always_comb begin
        grant_s = pick_winner(bus.req_valid, prefer1_s);
        if (!rst && (state_r == ST_IDLE) && (|bus.req_valid)) begin
            ready_s = req_onehot(grant_s);
        end else begin
            ready_s = {NUM_REQ{1'b0}};
        end
    end

    assign accept_s = |(bus.req_valid & ready_s);

    // Next-state logic for the job controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (len_r != {WIDTH{1'b0}}) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_RUN: begin
                // The increment that consumes the last step also finishes the job.
                if (!bus.pause && (remaining_r == {{(WIDTH-1){1'b0}}, 1'b1})) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= {NUM_REQ{1'b0}};
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_next_s == ST_DONE) ? req_onehot(owner_r)
                                                 : {NUM_REQ{1'b0}};
        end
    end

    // Job capture: start/len/owner are sampled only on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_r <= {WIDTH{1'b0}};
            len_r   <= {WIDTH{1'b0}};
            owner_r <= 1'b0;
        end else if (accept_s) begin
            start_r <= grant_s ? bus.req_start1 : bus.req_start0;
            len_r   <= grant_s ? bus.req_len1   : bus.req_len0;
            owner_r <= grant_s;
        end else begin
            start_r <= start_r;
            len_r   <= len_r;
            owner_r <= owner_r;
        end
    end

    // Remaining-increment counter, tracks the shared counter step for step.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_r <= {WIDTH{1'b0}};
        end else if (load_s) begin
            remaining_r <= len_r;
        end else if (inc_s) begin
            remaining_r <= remaining_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            remaining_r <= remaining_r;
        end
    end

`ifdef CNT_ARB_ROUND_ROBIN_EN
    // Remember who was granted last; reset value lets requester 0 win first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_r <= 1'b1;
        end else if (accept_s) begin
            rr_last_r <= grant_s;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end
`endif

    assign load_s = (state_r == ST_LOAD);
    assign inc_s  = (state_r == ST_RUN) && !bus.pause;

    ctr_load #(
        .WIDTH (WIDTH)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (start_r),
        .inc      (inc_s),
        .value    (count_s)
    );

    assign bus.req_ready = ready_s;
    assign bus.count     = count_s;
    assign bus.busy      = busy_r;
    assign bus.owner     = owner_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_counter_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_job_arbiter
// Directed self-checking bench for counter_job_arbiter: reset state, single
// jobs, counter wrap, zero-length job, pause, contention and mid-job reset.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_counter_job_arbiter;
    import counter_job_arbiter_pkg::*;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    counter_job_arbiter_if #(.WIDTH(W)) bus_if ();

    counter_job_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one job from requester r; pz inserts a 3-cycle pause early in RUN.
    task automatic do_job(input int r, input logic [W-1:0] st, input logic [W-1:0] ln,
                          input logic [W-1:0] fin, input bit pz);
        int               k;
        int               exp_cyc;
        bit               got;
        logic [1:0]       mask;
        logic [W-1:0]     st_plus1;
        mask     = 2'b00;
        mask[r]  = 1'b1;
        st_plus1 = st + 8'h01;
        if (r == 0) begin
            bus_if.req_start0 = st;
            bus_if.req_len0   = ln;
        end else begin
            bus_if.req_start1 = st;
            bus_if.req_len1   = ln;
        end
        bus_if.req_valid = mask;
        #1;
        check_value("accept_ready", 32'(bus_if.req_ready), 32'(mask));
        step();
        // Scramble inputs after acceptance: the job must not re-sample them.
        bus_if.req_valid  = 2'b00;
        bus_if.req_start0 = 8'hAA;
        bus_if.req_start1 = 8'hAA;
        bus_if.req_len0   = 8'h07;
        bus_if.req_len1   = 8'h07;
        check_value("load_busy", 32'(bus_if.busy), 32'd1);
        k   = 0;
        got = 1'b0;
        while (!got && k < 300) begin
            if (pz && k == 2) bus_if.pause = 1'b1;
            if (pz && k == 5) bus_if.pause = 1'b0;
            step();
            k++;
            if (k == 1) check_value("load_count", 32'(bus_if.count), 32'(st));
            if (pz && k >= 3 && k <= 5)
                check_value("pause_hold", 32'(bus_if.count), 32'(st_plus1));
            if (bus_if.done != 2'b00) got = 1'b1;
        end
        exp_cyc = int'(ln) + 1 + (pz ? 3 : 0);
        check_value("done_seen", 32'(got), 32'd1);
        check_value("done_latency", 32'(k), 32'(exp_cyc));
        check_value("final_count", 32'(bus_if.count), 32'(fin));
        check_value("done_bit", 32'(bus_if.done), 32'(mask));
        check_value("done_owner", 32'(bus_if.owner), 32'(r));
        check_value("done_busy", 32'(bus_if.busy), 32'd1);
        step();
        check_value("done_single", 32'(bus_if.done), 32'd0);
        check_value("idle_busy", 32'(bus_if.busy), 32'd0);
        check_value("idle_count_hold", 32'(bus_if.count), 32'(fin));
    endtask

    // Both requesters held valid; expect grants 0,1,0,1 (RR) or 0,0,0,0 (fixed).
    task automatic contention();
        int         w;
        int         exp_g;
        logic [1:0] exp_mask;
        bus_if.req_start0 = 8'h20;
        bus_if.req_len0   = 8'h01;
        bus_if.req_start1 = 8'h30;
        bus_if.req_len1   = 8'h01;
        bus_if.req_valid  = 2'b11;
        #1;
        for (int g = 0; g < 4; g++) begin
            w = 0;
            while (bus_if.req_ready == 2'b00 && w < 20) begin
                step();
                w++;
            end
`ifdef CNT_ARB_ROUND_ROBIN_EN
            exp_g = g % 2;
`else
            exp_g = 0;
`endif
            exp_mask = (exp_g == 1) ? 2'b10 : 2'b01;
            check_value("contend_grant", 32'(bus_if.req_ready), 32'(exp_mask));
            step();
            check_value("contend_owner", 32'(bus_if.owner), 32'(exp_g));
        end
        bus_if.req_valid = 2'b00;
        w = 0;
        while (bus_if.busy && w < 20) begin
            step();
            w++;
        end
        check_value("contend_drain", 32'(bus_if.busy), 32'd0);
    endtask

    // Abort a running job with reset and confirm the clean restart.
    task automatic reset_mid_run();
        bus_if.req_start0 = 8'h10;
        bus_if.req_len0   = 8'h0A;
        bus_if.req_valid  = 2'b01;
        step();
        bus_if.req_valid = 2'b00;
        step();
        step();
        step();
        check_value("pre_reset_count", 32'(bus_if.count), 32'h12);
        rst          = 1'b1;
        bus_if.pause = 1'b1;
        step();
        rst          = 1'b0;
        bus_if.pause = 1'b0;
        check_value("abort_count", 32'(bus_if.count), 32'd0);
        check_value("abort_busy", 32'(bus_if.busy), 32'd0);
        check_value("abort_owner", 32'(bus_if.owner), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_value("abort_no_done", 32'(bus_if.done), 32'd0);
            step();
        end
        bus_if.req_valid = 2'b11;
        #1;
        check_value("post_reset_grant", 32'(bus_if.req_ready), 32'h1);
        bus_if.req_valid = 2'b00;
        step();
    endtask

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        rst               = 1'b1;
        bus_if.req_valid  = 2'b00;
        bus_if.req_start0 = 8'h00;
        bus_if.req_start1 = 8'h00;
        bus_if.req_len0   = 8'h00;
        bus_if.req_len1   = 8'h00;
        bus_if.pause      = 1'b0;
        step();
        step();
        check_value("rst_count", 32'(bus_if.count), 32'd0);
        check_value("rst_busy", 32'(bus_if.busy), 32'd0);
        check_value("rst_owner", 32'(bus_if.owner), 32'd0);
        check_value("rst_done", 32'(bus_if.done), 32'd0);
        bus_if.req_valid = 2'b11;
        #1;
        check_value("rst_ready_blocked", 32'(bus_if.req_ready), 32'd0);
        bus_if.req_valid = 2'b00;
        rst              = 1'b0;
        step();

        do_job(0, 8'h10, 8'h04, 8'h14, 1'b0);
        do_job(1, 8'hFE, 8'h03, 8'h01, 1'b0);
        do_job(0, 8'h55, 8'h00, 8'h55, 1'b0);
        do_job(0, 8'h40, 8'h04, 8'h44, 1'b1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        contention();

        reset_mid_run();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/counter_job_arbiter.md
COUNTER_JOB_ARBITER -- requirements
Module: counter_job_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: width of the counter, start values and job lengths.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-004 req_valid  in  2  per-requester job request, bit i = requester i.
REQ-005 req_ready  out  2  per-requester accept; a job transfers when valid & ready are both high at a rising edge.
REQ-006 req_start0 / req_start1  in  WIDTH  counter start value of each requester's job.
REQ-007 req_len0 / req_len1  in  WIDTH  number of increments of each requester's job.
REQ-008 pause  in  1  freezes counting in RUN while high.
REQ-009 count  out  WIDTH  current shared counter value.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 owner  out  1  index of the requester owning the current job; holds its last value in IDLE.
REQ-012 done  out  2  one-cycle pulse on bit owner when that requester's job completes.

Function
REQ-013 The FSM SHALL have four states: IDLE, LOAD, RUN and DONE.
REQ-014 In IDLE, req_ready SHALL be asserted combinationally for exactly one requester (the arbitration winner) if any req_valid is high, and SHALL be 0 in all other states.
REQ-015 On the accepting edge, the block SHALL latch start, len and owner and go to LOAD.
REQ-016 In LOAD, the next edge SHALL set count=start and remaining=len, then go to RUN if len!=0, else to DONE.
REQ-017 In RUN, each edge with pause=0 SHALL do count<=count+1 (mod 2^WIDTH, wrapping max to 0) and remaining<=remaining-1.
REQ-018 In RUN, the edge that decrements remaining from 1 to 0 SHALL also move the FSM to DONE.
REQ-019 In RUN, edges with pause=1 SHALL change nothing.
REQ-020 pause SHALL be ignored in IDLE, LOAD and DONE.
REQ-021 In DONE, done[owner]=1 for that cycle only; the next edge SHALL return to IDLE, so back-to-back jobs are separated by at least one IDLE cycle.
REQ-022 The final count SHALL be (start+len) mod 2^WIDTH.
REQ-023 count SHALL hold its value in IDLE.
REQ-024 Requests SHALL NOT be queued; a requester's start/len SHALL be sampled only on its accepting edge.
REQ-025 A requester that deasserts valid before acceptance SHALL lose its request without side effects.

Reset
REQ-026 While rst is high at an edge: state=IDLE, count=0, remaining=0, owner=0, rr_last=1 (requester 0 wins first), done=0, busy=0, req_ready=0.
REQ-027 Reset mid-job SHALL abort the job with no done pulse.
REQ-028 rst SHALL override pause and any handshake.

Configuration
REQ-029 Macro CNT_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-030 With CNT_ARB_ROUND_ROBIN_EN defined: when both requesters are valid, the winner SHALL be the requester not granted last (rr_last), with rr_last updated on each accept.
REQ-031 Without CNT_ARB_ROUND_ROBIN_EN: fixed priority, requester 0 always wins, and rr_last is absent.
REQ-032 In both modes, a single valid requester SHALL always win.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (IDLE/LOAD/RUN/DONE, 2 bits), the requester count constant (2) and the default WIDTH.
REQ-034 The loadable counter SHALL be a sub-module ctr_load (inputs load, load_val, inc; output value) driven by the FSM.

Verification
REQ-035 Single job: req0 start=0x10, len=4, accepted at edge E -> count=0x10 after E+1, 0x14 after E+5, done[0] high in the cycle after edge E+5, busy low after E+6.
REQ-036 Wrap: start=0xFE, len=3 -> final count=0x01, done pulse once.
REQ-037 Zero length: start=0x55, len=0 -> LOAD then DONE, count=0x55, done pulse in the cycle after edge E+1.
REQ-038 Contention: both requesters valid continuously -> round-robin grants alternate 0,1,0,1 with owner matching; fixed priority grants only 0.
REQ-039 Pause: pause=1 for 3 cycles mid-RUN on a len=4 job -> count frozen during the pause, done delayed by exactly 3 cycles.
REQ-040 Reset mid-RUN: rst at RUN with count=0x12 -> next cycle count=0, IDLE, no done pulse, and the next contention is won by requester 0.
